strobe_compare: RTL and testbench
=================================

Name: strobe_compare

Overview:
- Receive-side counterpart of the force-format pin driver in the ASIC tester.
- Strobes the DUT output pin at programmed points within each tester cycle and compares the sample against the expected value, honouring a per-cycle mask.
- Reports per-cycle pass/fail, a saturating error count and the index of the first failing cycle.
- Shares the cycle timing convention of the pin driver: cycle counter runs 1..CYCLE_LENGTH in CLK ticks.

Parameters:
- ERR_W, 16, width of ERR_COUNT (saturating).
- IDX_W, 16, width of cycle index and FIRST_FAIL_IDX (wrapping).

Ports:
- CLK  in  1  tester clock.
- RST  in  1  asynchronous, active-low reset.
- EN  in  1  advance cycle counter and run compare; low freezes all state.
- CLR  in  1  synchronous clear of ERR_COUNT, FIRST_FAIL_*, cycle index; FSM to IDLE.
- CYCLE_LENGTH  in  8  ticks per tester cycle, 1..255.
- STROBE_START  in  7  tick at which compare begins.
- STROBE_END  in  7  last tick of window compare.
- MODE  in  2  00 EDGE, 01 WINDOW, 1x NONE.
- EXP  in  1  expected pin value for the cycle.
- MASK  in  1  1 = don't compare this cycle.
- DUT_IN  in  1  DUT output pin.
- CYCLE_DONE  out  1  one-CLK pulse when a cycle result is published.
- PASS  out  1  result of the last completed cycle.
- FAIL  out  1  result of the last completed cycle.
- ERR_COUNT  out  ERR_W  failing cycles, saturates at all-ones.
- FIRST_FAIL_VALID  out  1  a failure has been seen since reset/CLR.
- FIRST_FAIL_IDX  out  IDX_W  cycle index of the first failure.

Behaviour:
- Reset (RST low, async):
  - Counter = 1, cycle index = 0, FSM = IDLE.
  - All outputs 0.
  - Latched EXP/MASK/MODE = 0/1/NONE.
- Counter:
  - Updates only when EN = 1.
  - If counter == CYCLE_LENGTH it loads 1, else it increments.
  - When EN = 0 the counter holds and no samples are taken.
- Cycle start (EN and counter == 1): latch EXP, MASK, MODE. During that tick the compare uses the live inputs.
- FSM states:
  - IDLE -> ARMED on cycle start.
  - ARMED -> WINDOW when counter == STROBE_START and MODE = WINDOW.
  - WINDOW -> ARMED after counter == STROBE_END.
  - Any state -> REPORT on EN and counter == CYCLE_LENGTH.
  - REPORT -> ARMED if that same tick is a cycle start (back-to-back cycles), else IDLE.
- Sampling:
  - EDGE: mismatch flag set if the sample != EXP at counter == STROBE_START.
  - WINDOW: every tick in [STROBE_START, STROBE_END] inclusive is compared; any mismatch sets the flag.
  - STROBE_END < STROBE_START in WINDOW mode: behaves as EDGE.
  - NONE or MASK = 1: never fails.
- Missed strobe: STROBE_START == 0 or > CYCLE_LENGTH, unmasked, MODE not NONE -> cycle counts as FAIL.
- Report (registered, one CLK after the counter == CYCLE_LENGTH tick):
  - CYCLE_DONE = 1 for one CLK.
  - PASS/FAIL are complementary and hold until the next report.
  - On FAIL: ERR_COUNT += 1 unless already all-ones.
  - First FAIL sets FIRST_FAIL_VALID and captures the current cycle index; later fails do not overwrite.
  - Cycle index increments (wraps) after every report.
  - Mismatch flag clears for the next cycle.
- CYCLE_LENGTH = 1: every tick is start, strobe (if STROBE_START = 1) and end. Latch, compare and report all occur each tick, so CYCLE_DONE is high continuously while EN = 1.
- Simultaneous CLR and report: CLR wins, nothing is counted.
- RST asserted mid-cycle: partial cycle is discarded, no report.
- Timing inputs (CYCLE_LENGTH, STROBE_*) are sampled live. Changing them mid-cycle is permitted; the resulting cycle is defined only by the tick-by-tick rules above.

Optional Feature:
- Macro: STROBE_INPUT_SYNC_EN.
- Defined:
  - DUT_IN passes through a two-flop synchronizer, reset to 0.
  - Compares use the synchronized value, so the effective strobe point is 2 CLK after the programmed tick.
  - Programmers compensate via STROBE_START.
- Undefined: DUT_IN is sampled directly at the programmed tick, with zero added latency.

Test Plan:
- CYCLE_LENGTH = 8, EDGE, STROBE_START = 4, EXP = 1, DUT_IN = 1 for 3 cycles -> 3 CYCLE_DONE pulses spaced 8 CLK apart; PASS = 1; ERR_COUNT = 0.
- Same setup, DUT_IN = 0 only at tick 4 of cycle 2 -> that cycle FAIL = 1; ERR_COUNT = 1; FIRST_FAIL_VALID = 1; FIRST_FAIL_IDX = 1.
- WINDOW, START = 3, END = 6, EXP = 0, DUT_IN glitches to 1 at tick 6 -> FAIL. Repeat with the glitch at tick 7 -> PASS.
- MASK = 1 with DUT_IN mismatching, then STROBE_START = 9 with CYCLE_LENGTH = 8 unmasked -> PASS, then FAIL (missed strobe); ERR_COUNT = 1.
- Preload ERR_COUNT near max (ERR_W = 4, 16 failing cycles) -> ERR_COUNT stays 4'hF. Then CLR -> all counters 0, FIRST_FAIL_VALID = 0.
- RST low at tick 5 of a failing cycle, then release -> no CYCLE_DONE, outputs 0, counter restarts at 1. With STROBE_INPUT_SYNC_EN, a mismatch at tick 4 is detected only with STROBE_START = 6.

Source files
------------

// File: rtl/strobe_compare.sv
// ---------------------------------------------------------------------------
// strobe_compare
//
// Receive-side partner of the force-format pin driver. Within every tester
// cycle it strobes the DUT output pin at programmed ticks and compares the
// sample against the value expected for that cycle. It reports a per-cycle
// PASS/FAIL, a saturating error count and the index of the first failing
// cycle. The tick counter runs 1..CYCLE_LENGTH in CLK ticks, the same
// convention the pin driver uses.
//
// Optional feature (compile-time macro STROBE_INPUT_SYNC_EN):
//   defined   - DUT_IN passes through a two-flop synchronizer (reset to 0).
//               Every compare then sees the pin value from 2 CLK earlier, so
//               STROBE_START has to be programmed 2 ticks later.
//   undefined - DUT_IN is compared directly at the programmed tick.
//
// Parameters:
//   ERR_W            width of ERR_COUNT (saturating)
//   IDX_W            width of the cycle index and FIRST_FAIL_IDX (wrapping)
//
// Ports:
//   CLK              tester clock
//   RST              asynchronous reset, active low
//   EN               advances the tick counter and runs the compare; low freezes
//   CLR              synchronous clear of the error bookkeeping and cycle index
//   CYCLE_LENGTH     ticks per tester cycle (1..255)
//   STROBE_START     tick at which comparing begins
//   STROBE_END       last tick of a window compare
//   MODE             00 EDGE, 01 WINDOW, 1x NONE
//   EXP              expected pin value, taken at cycle start
//   MASK             1 = do not compare this cycle, taken at cycle start
//   DUT_IN           DUT output pin
//   CYCLE_DONE       one-CLK pulse when a cycle result is published
//   PASS / FAIL      complementary result of the last completed cycle
//   ERR_COUNT        number of failing cycles, saturates at all-ones
//   FIRST_FAIL_VALID a failure has been seen since reset or CLR
//   FIRST_FAIL_IDX   cycle index of that first failure
// ---------------------------------------------------------------------------
module strobe_compare #(
    parameter int ERR_W = 16,
    parameter int IDX_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             CLR,
    input  logic [7:0]       CYCLE_LENGTH,
    input  logic [6:0]       STROBE_START,
    input  logic [6:0]       STROBE_END,
    input  logic [1:0]       MODE,
    input  logic             EXP,
    input  logic             MASK,
    input  logic             DUT_IN,
    output logic             CYCLE_DONE,
    output logic             PASS,
    output logic             FAIL,
    output logic [ERR_W-1:0] ERR_COUNT,
    output logic             FIRST_FAIL_VALID,
    output logic [IDX_W-1:0] FIRST_FAIL_IDX
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_WINDOW,
        S_REPORT
    } state_t;

    localparam logic [1:0]       MODE_WINDOW = 2'b01;
    localparam logic [1:0]       MODE_NONE   = 2'b10;
    localparam logic [ERR_W-1:0] ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_ONE     = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [7:0]       tick_cnt;
    logic [IDX_W-1:0] cycle_idx;
    logic             lat_exp;
    logic             lat_mask;
    logic [1:0]       lat_mode;
    logic             mismatch_flag;

    logic             sample;
    logic             cycle_start;
    logic             cycle_end;
    logic             eff_exp;
    logic             eff_mask;
    logic [1:0]       eff_mode;
    logic [7:0]       start_tick;
    logic [7:0]       end_tick;
    logic             edge_hit;
    logic             window_mode;
    logic             enter_window;
    logic             compare_active;
    logic             compare_now;
    logic             tick_mismatch;
    logic             missed_strobe;
    logic             flag_base;
    logic             cycle_fail;

`ifdef STROBE_INPUT_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    // Two-flop synchronizer on the pin. It free-runs regardless of EN so the
    // pipeline always holds the most recent pin history.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= DUT_IN;
            sync_q2 <= sync_q1;
        end
    end

    assign sample = sync_q2;
`else
    assign sample = DUT_IN;
`endif

    // Tick decode. On the cycle-start tick the per-cycle controls are not
    // latched yet, so the live EXP/MASK/MODE are used for that tick only.
    always_comb begin
        cycle_start = (tick_cnt == 8'd1);
        cycle_end   = (tick_cnt == CYCLE_LENGTH);
        eff_exp     = cycle_start ? EXP  : lat_exp;
        eff_mask    = cycle_start ? MASK : lat_mask;
        eff_mode    = cycle_start ? MODE : lat_mode;
        start_tick  = {1'b0, STROBE_START};
        end_tick    = {1'b0, STROBE_END};
    end

    // Compare decision for the current tick. A window whose end lies before
    // its start degenerates to a single edge strobe at STROBE_START; a window
    // of one tick never needs the WINDOW state. MODE 1x compares nothing.
    always_comb begin
        edge_hit       = (tick_cnt == start_tick);
        window_mode    = (eff_mode == MODE_WINDOW) && (end_tick >= start_tick);
        enter_window   = window_mode && edge_hit && (end_tick != start_tick);
        compare_active = !eff_mask && !eff_mode[1];
        compare_now    = compare_active && (edge_hit || state == S_WINDOW);
        tick_mismatch  = compare_now && (sample != eff_exp);
        missed_strobe  = compare_active &&
                         ((STROBE_START == 7'd0) || (start_tick > CYCLE_LENGTH));
        flag_base      = cycle_start ? 1'b0 : mismatch_flag;
        cycle_fail     = flag_base || tick_mismatch || missed_strobe;
    end

    // Main sequencer: tick counter, per-cycle latches, mismatch accumulation,
    // FSM and the registered report. CLR takes priority over a report landing
    // on the same tick, so that cycle is never counted. EN low freezes all of
    // it; only the CYCLE_DONE pulse drops back to 0.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state            <= S_IDLE;
            tick_cnt         <= 8'd1;
            cycle_idx        <= '0;
            lat_exp          <= 1'b0;
            lat_mask         <= 1'b1;
            lat_mode         <= MODE_NONE;
            mismatch_flag    <= 1'b0;
            CYCLE_DONE       <= 1'b0;
            PASS             <= 1'b0;
            FAIL             <= 1'b0;
            ERR_COUNT        <= '0;
            FIRST_FAIL_VALID <= 1'b0;
            FIRST_FAIL_IDX   <= '0;
        end else if (CLR) begin
            state            <= S_IDLE;
            tick_cnt         <= 8'd1;
            cycle_idx        <= '0;
            mismatch_flag    <= 1'b0;
            CYCLE_DONE       <= 1'b0;
            ERR_COUNT        <= '0;
            FIRST_FAIL_VALID <= 1'b0;
            FIRST_FAIL_IDX   <= '0;
        end else begin
            CYCLE_DONE <= 1'b0;
            if (EN) begin
                tick_cnt <= cycle_end ? 8'd1 : tick_cnt + 8'd1;

                if (cycle_start) begin
                    lat_exp  <= EXP;
                    lat_mask <= MASK;
                    lat_mode <= MODE;
                end

                mismatch_flag <= cycle_end ? 1'b0 : (flag_base || tick_mismatch);

                if (cycle_end) begin
                    state      <= S_REPORT;
                    CYCLE_DONE <= 1'b1;
                    PASS       <= !cycle_fail;
                    FAIL       <= cycle_fail;
                    if (cycle_fail) begin
                        if (ERR_COUNT != ERR_MAX) begin
                            ERR_COUNT <= ERR_COUNT + ERR_ONE;
                        end
                        if (!FIRST_FAIL_VALID) begin
                            FIRST_FAIL_VALID <= 1'b1;
                            FIRST_FAIL_IDX   <= cycle_idx;
                        end
                    end
                    cycle_idx <= cycle_idx + IDX_ONE;
                end else if (cycle_start) begin
                    state <= enter_window ? S_WINDOW : S_ARMED;
                end else begin
                    case (state)
                        S_ARMED: begin
                            if (enter_window) begin
                                state <= S_WINDOW;
                            end
                        end
                        S_WINDOW: begin
                            if (tick_cnt == end_tick) begin
                                state <= S_ARMED;
                            end
                        end
                        S_REPORT: begin
                            state <= S_IDLE;
                        end
                        default: begin
                            state <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_strobe_compare.sv
// ---------------------------------------------------------------------------
// tb_strobe_compare
//
// Self-checking bench for strobe_compare (built with ERR_W = 4 so that
// saturation is reachable quickly). Every CLK edge's pin value is recorded;
// at the end of each cycle the expected result is computed from the compare
// rules (edge, window, mask, missed strobe, optional two-flop delay) over
// that recorded history, and the bookkeeping outputs are predicted with
// plain integer arithmetic.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_strobe_compare;

    localparam int ERR_W = 4;
    localparam int IDX_W = 16;

    logic             CLK = 1'b0;
    logic             RST;
    logic             EN;
    logic             CLR;
    logic [7:0]       CYCLE_LENGTH;
    logic [6:0]       STROBE_START;
    logic [6:0]       STROBE_END;
    logic [1:0]       MODE;
    logic             EXP;
    logic             MASK;
    logic             DUT_IN;
    logic             CYCLE_DONE;
    logic             PASS;
    logic             FAIL;
    logic [ERR_W-1:0] ERR_COUNT;
    logic             FIRST_FAIL_VALID;
    logic [IDX_W-1:0] FIRST_FAIL_IDX;

    always #5 CLK = ~CLK;

    strobe_compare #(
        .ERR_W (ERR_W),
        .IDX_W (IDX_W)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .EN               (EN),
        .CLR              (CLR),
        .CYCLE_LENGTH     (CYCLE_LENGTH),
        .STROBE_START     (STROBE_START),
        .STROBE_END       (STROBE_END),
        .MODE             (MODE),
        .EXP              (EXP),
        .MASK             (MASK),
        .DUT_IN           (DUT_IN),
        .CYCLE_DONE       (CYCLE_DONE),
        .PASS             (PASS),
        .FAIL             (FAIL),
        .ERR_COUNT        (ERR_COUNT),
        .FIRST_FAIL_VALID (FIRST_FAIL_VALID),
        .FIRST_FAIL_IDX   (FIRST_FAIL_IDX)
    );

    int checks = 0;
    int errors = 0;

    // Pin value present at every CLK edge since the last reset release.
    bit hist[$];

    // Reference bookkeeping.
    int m_err;
    bit m_ffv;
    int m_ffidx;
    int m_idx;
    bit m_pass;
    bit m_fail;

    // Safety net in case the run ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_err   = 0;
        m_ffv   = 0;
        m_ffidx = 0;
        m_idx   = 0;
        m_pass  = 0;
        m_fail  = 0;
    endtask

    task automatic model_clear();
        m_err   = 0;
        m_ffv   = 0;
        m_ffidx = 0;
        m_idx   = 0;
    endtask

    // Record the pin value seen by this edge, then move to 1 ns past it.
    task automatic clock_tick();
        hist.push_back(DUT_IN);
        @(posedge CLK);
        #1;
    endtask

    // Value the compare logic sees for the edge at history position gidx.
    function automatic bit sampled(input int gidx);
`ifdef STROBE_INPUT_SYNC_EN
        if (gidx < 2) return 1'b0;
        return hist[gidx-2];
`else
        return hist[gidx];
`endif
    endfunction

    task automatic do_clear();
        EN     = 1'b0;
        CLR    = 1'b1;
        DUT_IN = 1'b0;
        clock_tick();
        CLR = 1'b0;
        model_clear();
        check_output("clr_done",  32'(CYCLE_DONE),       32'(0));
        check_output("clr_err",   32'(ERR_COUNT),        32'(m_err));
        check_output("clr_ffv",   32'(FIRST_FAIL_VALID), 32'(m_ffv));
        check_output("clr_ffidx", 32'(FIRST_FAIL_IDX),   32'(m_ffidx));
    endtask

    // One complete tester cycle. EXP/MASK/MODE are valid only on tick 1 and
    // carry junk afterwards; optional EN-low stalls are inserted between ticks.
    task automatic apply_stimulus(input int len, input int mode, input int s, input int e,
                                  input bit exp_v, input bit mask_v, input logic [255:0] pat,
                                  input bit stalls, input bit clr_last);
        int tick_idx [256];
        int n;
        int last;
        bit f;
        for (int t = 1; t <= len; t++) begin
            if (stalls && t > 1) begin
                n = $urandom_range(0, 2);
                for (int k = 0; k < n; k++) begin
                    EN     = 1'b0;
                    DUT_IN = 1'($urandom);
                    MODE   = 2'($urandom);
                    EXP    = 1'($urandom);
                    MASK   = 1'($urandom);
                    clock_tick();
                    check_output("done_stall", 32'(CYCLE_DONE), 32'(0));
                end
            end
            EN           = 1'b1;
            CLR          = clr_last && (t == len);
            CYCLE_LENGTH = 8'(len);
            STROBE_START = 7'(s);
            STROBE_END   = 7'(e);
            if (t == 1) begin
                MODE = 2'(mode);
                EXP  = exp_v;
                MASK = mask_v;
            end else begin
                MODE = 2'($urandom);
                EXP  = 1'($urandom);
                MASK = 1'($urandom);
            end
            DUT_IN      = pat[t];
            tick_idx[t] = hist.size();
            clock_tick();
            if (t < len) begin
                check_output("done_mid",  32'(CYCLE_DONE), 32'(0));
                check_output("pass_hold", 32'(PASS),       32'(m_pass));
            end
        end
        CLR = 1'b0;

        f = 1'b0;
        if (!mask_v && mode < 2) begin
            if (s == 0 || s > len) begin
                f = 1'b1;
            end else if (mode == 1 && e >= s) begin
                last = (e < len) ? e : len;
                for (int t = s; t <= last; t++) begin
                    if (sampled(tick_idx[t]) != exp_v) f = 1'b1;
                end
            end else begin
                f = (sampled(tick_idx[s]) != exp_v);
            end
        end

        if (clr_last) begin
            model_clear();
            check_output("clr_done",  32'(CYCLE_DONE),       32'(0));
            check_output("clr_err",   32'(ERR_COUNT),        32'(m_err));
            check_output("clr_ffv",   32'(FIRST_FAIL_VALID), 32'(m_ffv));
            check_output("clr_ffidx", 32'(FIRST_FAIL_IDX),   32'(m_ffidx));
        end else begin
            if (f) begin
                if (m_err < (1 << ERR_W) - 1) m_err++;
                if (!m_ffv) begin
                    m_ffv   = 1'b1;
                    m_ffidx = m_idx;
                end
            end
            m_idx  = (m_idx + 1) % (1 << IDX_W);
            m_pass = !f;
            m_fail = f;
            check_output("done_report", 32'(CYCLE_DONE),       32'(1));
            check_output("pass_out",    32'(PASS),             32'(m_pass));
            check_output("fail_out",    32'(FAIL),             32'(m_fail));
            check_output("err_count",   32'(ERR_COUNT),        32'(m_err));
            check_output("ff_valid",    32'(FIRST_FAIL_VALID), 32'(m_ffv));
            check_output("ff_idx",      32'(FIRST_FAIL_IDX),   32'(m_ffidx));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_done"},  32'(CYCLE_DONE),       32'(0));
        check_output({tag, "_pass"},  32'(PASS),             32'(0));
        check_output({tag, "_fail"},  32'(FAIL),             32'(0));
        check_output({tag, "_err"},   32'(ERR_COUNT),        32'(0));
        check_output({tag, "_ffv"},   32'(FIRST_FAIL_VALID), 32'(0));
        check_output({tag, "_ffidx"}, 32'(FIRST_FAIL_IDX),   32'(0));
    endtask

    initial begin
        logic [255:0] pat;
        int len;
        int md;
        bit ev;

        RST          = 1'b0;
        EN           = 1'b0;
        CLR          = 1'b0;
        CYCLE_LENGTH = 8'd8;
        STROBE_START = 7'd0;
        STROBE_END   = 7'd0;
        MODE         = 2'b00;
        EXP          = 1'b0;
        MASK         = 1'b0;
        DUT_IN       = 1'b0;
        model_reset();

        // Reset state
        @(posedge CLK);
        #1;
        check_all_zero("rst_init");
        RST = 1'b1;
        hist.delete();

        // Edge strobe at tick 4, matching pin, three back-to-back cycles
        pat = '1;
        for (int c = 0; c < 3; c++) apply_stimulus(8, 0, 4, 0, 1'b1, 1'b0, pat, 1'b0, 1'b0);

        // Pin low only at tick 4 of the second cycle
        do_clear();
        for (int c = 0; c < 3; c++) begin
            pat = '1;
            if (c == 1) pat[4] = 1'b0;
            apply_stimulus(8, 0, 4, 0, 1'b1, 1'b0, pat, 1'b0, 1'b0);
        end

        // Window 3..6, glitch at tick 6 then at tick 7
        do_clear();
        pat = '0; pat[6] = 1'b1;
        apply_stimulus(8, 1, 3, 6, 1'b0, 1'b0, pat, 1'b0, 1'b0);
        pat = '0; pat[7] = 1'b1;
        apply_stimulus(8, 1, 3, 6, 1'b0, 1'b0, pat, 1'b0, 1'b0);

        // Masked mismatch, then strobe beyond the cycle length
        do_clear();
        pat = '0;
        apply_stimulus(8, 0, 4, 0, 1'b1, 1'b1, pat, 1'b0, 1'b0);
        pat = '1;
        apply_stimulus(8, 0, 9, 0, 1'b1, 1'b0, pat, 1'b0, 1'b0);
        check_output("missed_err", 32'(ERR_COUNT), 32'(1));

        // Window with end before start acts as an edge strobe
        pat = '1; pat[5] = 1'b0;
        apply_stimulus(8, 1, 5, 2, 1'b1, 1'b0, pat, 1'b0, 1'b0);
        pat = '1; pat[3] = 1'b0;
        apply_stimulus(8, 1, 5, 2, 1'b1, 1'b0, pat, 1'b0, 1'b0);

        // One-tick cycles: report every tick
        for (int c = 0; c < 6; c++) begin
            pat = '0;
            pat[1] = 1'($urandom);
            apply_stimulus(1, 0, 1, 1, 1'b1, 1'b0, pat, 1'b0, 1'b0);
        end

        // Mismatch at tick 4 strobed at tick 4 and at tick 6
        pat = '1; pat[4] = 1'b0;
        apply_stimulus(8, 0, 4, 0, 1'b1, 1'b0, pat, 1'b0, 1'b0);
        apply_stimulus(8, 0, 6, 0, 1'b1, 1'b0, pat, 1'b0, 1'b0);

        // Randomized cycles with stalls
        for (int c = 0; c < 40; c++) begin
            len = $urandom_range(1, 20);
            md  = $urandom_range(0, 3);
            ev  = 1'($urandom);
            for (int i = 0; i < 256; i++) pat[i] = ev ^ ($urandom_range(0, 5) == 0);
            apply_stimulus(len, md, $urandom_range(0, 22), $urandom_range(0, 22), ev,
                           ($urandom_range(0, 3) == 0), pat, 1'b1, 1'b0);
        end

        // Saturation of the 4-bit error counter
        do_clear();
        pat = '0;
        for (int c = 0; c < 18; c++) apply_stimulus(4, 0, 0, 0, 1'b1, 1'b0, pat, 1'b0, 1'b0);
        check_output("err_sat", 32'(ERR_COUNT), 32'(15));

        // CLR on the reporting tick wins
        apply_stimulus(4, 0, 0, 0, 1'b1, 1'b0, pat, 1'b0, 1'b1);

        // Reset at tick 5 of a failing cycle
        apply_stimulus(4, 0, 0, 0, 1'b1, 1'b0, pat, 1'b0, 1'b0);
        pat = '1; pat[4] = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            EN           = 1'b1;
            CYCLE_LENGTH = 8'd8;
            STROBE_START = 7'd4;
            STROBE_END   = 7'd0;
            MODE         = 2'b00;
            EXP          = 1'b1;
            MASK         = 1'b0;
            DUT_IN       = pat[t];
            clock_tick();
        end
        DUT_IN = 1'b1;
        #2;
        RST = 1'b0;
        #1;
        check_all_zero("rst_mid");
        for (int k = 0; k < 3; k++) begin
            clock_tick();
            check_output("rst_hold_done", 32'(CYCLE_DONE), 32'(0));
        end
        RST = 1'b1;
        hist.delete();
        model_reset();
        pat = '1;
        apply_stimulus(8, 0, 4, 0, 1'b1, 1'b0, pat, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
